// File: rtl/axis_crop_ctrl.sv
// Tracks pixel/line position of a snooped AXIS video stream and qualifies each beat against a crop
// window held in shadow registers; the window only changes between frames.
module axis_crop_ctrl #(
   parameter int VIDEO_IN_W  = 1920,
   parameter int VIDEO_IN_H  = 1080,
   parameter int H_OFFSET    = 640,
   parameter int V_OFFSET    = 300,
   parameter int VIDEO_OUT_W = 640,
   parameter int VIDEO_OUT_H = 480
) (
   input  logic        axis_clk,
   input  logic        aresetn,
   input  logic        cfg_wr_en,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   input  logic        cfg_commit,
   output logic        cfg_busy,
   output logic        cfg_err,
   input  logic        mon_tvalid,
   input  logic        mon_tready,
   input  logic        mon_tuser,
   input  logic        mon_tlast,
   output logic        win_keep,
   output logic        win_sof,
   output logic        win_eol,
   output logic        line_err,
   output logic        sof_err
);
   localparam logic [0:0]  ST_WAIT_SOF = 1'b0;
   localparam logic [0:0]  ST_ACTIVE   = 1'b1;
   localparam logic [15:0] X_LAST      = 16'(VIDEO_IN_W - 1);
   localparam logic [15:0] Y_LAST      = 16'(VIDEO_IN_H - 1);
   localparam logic [16:0] IN_W17      = 17'(VIDEO_IN_W);
   localparam logic [16:0] IN_H17      = 17'(VIDEO_IN_H);

   logic [0:0]  state_q, state_d;
   logic [15:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic        line_err_q, line_err_d, sof_err_q, sof_err_d;
   logic [15:0] act_hoff_q, act_voff_q, act_w_q, act_h_q;
   logic [15:0] pnd_hoff_q, pnd_voff_q, pnd_w_q, pnd_h_q;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic        beat, live, frame_end;
   logic [15:0] x_cur, y_cur;
   logic [16:0] h_end, v_end;
   logic        in_x, in_y;
   logic        pend_ok, commit_ok, at_boundary, apply;

   assign beat  = mon_tvalid && mon_tready;
   assign live  = (state_q == ST_ACTIVE) || mon_tuser;
   assign x_cur = mon_tuser ? 16'd0 : h_cnt_q;
   assign y_cur = mon_tuser ? 16'd0 : v_cnt_q;

   assign h_end = {1'b0, act_hoff_q} + {1'b0, act_w_q};
   assign v_end = {1'b0, act_voff_q} + {1'b0, act_h_q};
   assign in_x  = (x_cur >= act_hoff_q) && ({1'b0, x_cur} < h_end);
   assign in_y  = (y_cur >= act_voff_q) && ({1'b0, y_cur} < v_end);

   assign win_keep = mon_tvalid && live && in_x && in_y;
   assign win_sof  = win_keep && (x_cur == act_hoff_q) && (y_cur == act_voff_q);
   assign win_eol  = win_keep && ({1'b0, x_cur} == (h_end - 17'd1));

   // A tuser beat is always processed as coordinate (0,0), whether it starts or restarts a frame.
   always_comb begin
      state_d    = state_q;
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      line_err_d = 1'b0;
      sof_err_d  = 1'b0;
      frame_end  = 1'b0;
      if (beat && live) begin
         state_d   = ST_ACTIVE;
         sof_err_d = (state_q == ST_ACTIVE) && mon_tuser && ((h_cnt_q != 16'd0) || (v_cnt_q != 16'd0));
         if ((x_cur == X_LAST) && mon_tlast) begin
            h_cnt_d = 16'd0;
            if (y_cur == Y_LAST) begin
               frame_end = 1'b1;
               state_d   = ST_WAIT_SOF;
               v_cnt_d   = 16'd0;
            end else begin
               v_cnt_d = y_cur + 16'd1;
            end
         end else if ((x_cur == X_LAST) || mon_tlast) begin
            line_err_d = 1'b1;
            state_d    = ST_WAIT_SOF;
            h_cnt_d    = 16'd0;
            v_cnt_d    = 16'd0;
         end else begin
            h_cnt_d = x_cur + 16'd1;
            v_cnt_d = y_cur;
         end
      end
   end

   assign pend_ok = (pnd_w_q != 16'd0) && (pnd_h_q != 16'd0) &&
                    (({1'b0, pnd_hoff_q} + {1'b0, pnd_w_q}) <= IN_W17) &&
                    (({1'b0, pnd_voff_q} + {1'b0, pnd_h_q}) <= IN_H17);
   assign commit_ok   = cfg_commit && pend_ok;
   assign at_boundary = ((state_q == ST_WAIT_SOF) && !beat) || frame_end;
   // done_q marks a busy cycle whose commit was already applied on the edge that raised it.
   assign apply  = (commit_ok || (busy_q && !done_q)) && at_boundary;
   assign done_d = apply && commit_ok;
   assign err_d  = cfg_commit ? !pend_ok : err_q;

   always_comb begin
      busy_d = busy_q;
      if (commit_ok) begin
         busy_d = 1'b1;
      end else if (done_q || apply) begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge axis_clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= ST_WAIT_SOF;
         h_cnt_q    <= 16'd0;
         v_cnt_q    <= 16'd0;
         line_err_q <= 1'b0;
         sof_err_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         act_hoff_q <= 16'(H_OFFSET);
         act_voff_q <= 16'(V_OFFSET);
         act_w_q    <= 16'(VIDEO_OUT_W);
         act_h_q    <= 16'(VIDEO_OUT_H);
         pnd_hoff_q <= 16'(H_OFFSET);
         pnd_voff_q <= 16'(V_OFFSET);
         pnd_w_q    <= 16'(VIDEO_OUT_W);
         pnd_h_q    <= 16'(VIDEO_OUT_H);
      end else begin
         state_q    <= state_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         line_err_q <= line_err_d;
         sof_err_q  <= sof_err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         if (apply) begin
            act_hoff_q <= pnd_hoff_q;
            act_voff_q <= pnd_voff_q;
            act_w_q    <= pnd_w_q;
            act_h_q    <= pnd_h_q;
         end
         if (cfg_wr_en) begin
            case (cfg_addr)
               2'd0:    pnd_hoff_q <= cfg_wdata;
               2'd1:    pnd_voff_q <= cfg_wdata;
               2'd2:    pnd_w_q    <= cfg_wdata;
               default: pnd_h_q    <= cfg_wdata;
            endcase
         end
      end
   end

   assign cfg_busy = busy_q;
   assign cfg_err  = err_q;
   assign line_err = line_err_q;
   assign sof_err  = sof_err_q;

endmodule

// File: tb/tb_axis_crop_ctrl.sv
// Randomised scoreboard bench for axis_crop_ctrl on an 8x4 input raster with a 3x2 default window at (2,1).
module tb_axis_crop_ctrl;
   localparam int W = 8;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        aresetn, cfg_wr_en, cfg_commit, cfg_busy, cfg_err;
   logic [1:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic        mon_tvalid, mon_tready, mon_tuser, mon_tlast;
   logic        win_keep, win_sof, win_eol, line_err, sof_err;

   always #5 clk = ~clk;

   axis_crop_ctrl #(
      .VIDEO_IN_W(W), .VIDEO_IN_H(H), .H_OFFSET(2), .V_OFFSET(1), .VIDEO_OUT_W(3), .VIDEO_OUT_H(2)
   ) dut (
      .axis_clk(clk), .aresetn(aresetn),
      .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
      .cfg_busy(cfg_busy), .cfg_err(cfg_err),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
      .win_keep(win_keep), .win_sof(win_sof), .win_eol(win_eol), .line_err(line_err), .sof_err(sof_err)
   );

   typedef struct { bit k; bit s; bit e; } qual_t;
   typedef struct { int c; bit l; bit s; } errev_t;
   qual_t  qq[$];
   errev_t eq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: window as {hoff, voff, w, h}; frame position as a linear beat index.
   int act[4];
   int pnd[4];
   bit in_frame;
   int pos;
   bit pend_commit;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic bit pend_ok();
      return pnd[2] != 0 && pnd[3] != 0 && pnd[0] + pnd[2] <= W && pnd[1] + pnd[3] <= H;
   endfunction

   task automatic model_reset();
      act = '{2, 1, 3, 2};
      pnd = act;
      in_frame = 0;
      pos = 0;
      pend_commit = 0;
      qq.delete();
      eq.delete();
   endtask

   // Monitor: compares qualifiers on every beat and error pulses on every cycle.
   always @(negedge clk) begin
      if (aresetn) begin
         if (mon_tvalid && mon_tready) begin
            if (qq.size() == 0) begin
               chk("qual_queue_underflow", 1, 0);
            end else begin
               qual_t q;
               q = qq.pop_front();
               chk("win_keep", win_keep, q.k);
               chk("win_sof", win_sof, q.s);
               chk("win_eol", win_eol, q.e);
            end
         end
         begin
            bit el, es;
            el = 0;
            es = 0;
            if (eq.size() > 0 && eq[0].c == cyc) begin
               el = eq[0].l;
               es = eq[0].s;
               void'(eq.pop_front());
            end
            if (el || es || line_err || sof_err) begin
               chk("line_err", line_err, el);
               chk("sof_err", sof_err, es);
            end
         end
      end
   end

   task automatic step(input bit v, input bit r, input bit u, input bit l,
                       input bit we, input int a, input int d, input bit cm);
      bit bt, se, le, fe, was_in, ok;
      int x, y;
      qual_t q;
      mon_tvalid = v; mon_tready = r; mon_tuser = u; mon_tlast = l;
      cfg_wr_en = we; cfg_addr = a[1:0]; cfg_wdata = d[15:0]; cfg_commit = cm;
      was_in = in_frame; ok = 0; se = 0; le = 0; fe = 0;
      if (cm) begin
         ok = pend_ok();
         if (ok) pend_commit = 1;
      end
      bt = v && r;
      if (bt) begin
         if (u) begin
            se = in_frame && pos != 0;
            in_frame = 1;
            pos = 0;
         end
         q = '{0, 0, 0};
         if (in_frame) begin
            x = pos % W;
            y = pos / W;
            q.k = x >= act[0] && x < act[0] + act[2] && y >= act[1] && y < act[1] + act[3];
            q.s = q.k && x == act[0] && y == act[1];
            q.e = q.k && x == act[0] + act[2] - 1;
            if (l != (x == W - 1)) begin
               le = 1;
               in_frame = 0;
            end else begin
               pos++;
               if (pos == W * H) begin
                  fe = 1;
                  in_frame = 0;
               end
            end
         end
         qq.push_back(q);
      end
      if (se || le) eq.push_back('{cyc + 1, le, se});
      if (pend_commit && ((!was_in && !bt) || fe)) begin
         act = pnd;
         pend_commit = 0;
      end
      if (we) pnd[a] = d;
      @(posedge clk);
      #1;
      cfg_wr_en = 0;
      cfg_commit = 0;
      if (cm) begin
         chk("cfg_err_after_commit", cfg_err, !ok);
         if (ok) chk("cfg_busy_after_commit", cfg_busy, 1);
      end
   endtask

   task automatic idle();            step(0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic wr(input int a, input int d); step(0, 0, 0, 0, 1, a, d, 0); endtask
   task automatic commit();          step(0, 0, 0, 0, 0, 0, 0, 1); endtask
   task automatic junk(input bit l); step(1, 1, 0, l, 0, 0, 0, 0); endtask

   task automatic set_win(input int ho, input int vo, input int w, input int h);
      wr(0, ho); wr(1, vo); wr(2, w); wr(3, h);
   endtask

   // One beat preceded by 0..2 random non-beat cycles (valid or ready low, noisy sideband).
   task automatic beat(input bit u, input bit l);
      int n;
      bit v;
      n = $urandom_range(0, 2);
      repeat (n) begin
         v = 1'($urandom_range(0, 1));
         step(v, v ? 1'b0 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 0, 0, 0, 0);
      end
      step(1, 1, u, l, 0, 0, 0, 0);
   endtask

   task automatic send_clean();
      for (int p = 0; p < W * H; p++) beat(p == 0, (p % W) == W - 1);
   endtask

   // fault: 0 none, 1 early tlast, 2 missing tlast, 3 tuser restart, 4 stop silently at fpos.
   task automatic send_frame(input int fault, input int fpos, input int cpos, input int stall);
      for (int p = 0; p < W * H; p++) begin
         if (p == cpos) commit();
         if (cpos >= 0 && p == cpos + 5) chk("cfg_busy_hold", cfg_busy, pend_commit);
         if (p == stall) repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
         if (p == fpos && fault != 0) begin
            case (fault)
               1: beat(p == 0, 1);
               2: beat(p == 0, 0);
               3: send_clean();
               default: ;
            endcase
            return;
         end
         beat(p == 0, (p % W) == W - 1);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int fault, fpos, cpos, stall, ho, vo, w, h;
      aresetn = 0;
      mon_tvalid = 1; mon_tready = 1; mon_tuser = 1; mon_tlast = 0;
      cfg_wr_en = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_win_keep", win_keep, 0);
      chk("rst_win_sof", win_sof, 0);
      chk("rst_win_eol", win_eol, 0);
      chk("rst_cfg_busy", cfg_busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_line_err", line_err, 0);
      chk("rst_sof_err", sof_err, 0);
      mon_tvalid = 0; mon_tuser = 0;
      aresetn = 1;
      idle(); idle();

      send_frame(0, -1, -1, -1);
      idle();

      wr(0, 5); wr(2, 4);
      commit();
      chk("invalid_commit_busy", cfg_busy, 0);
      send_frame(0, -1, -1, -1);
      idle();

      set_win(0, 0, 8, 4);
      send_frame(0, -1, 13, -1);
      idle(); idle();
      chk("busy_clear_after_frame", cfg_busy, 0);
      chk("err_clear_after_valid", cfg_err, 0);
      send_frame(0, -1, -1, -1);

      set_win(2, 1, 3, 2);
      commit();
      idle();
      send_frame(1, W + 5, -1, -1);
      junk(0); junk(1); junk(0);
      send_frame(0, -1, -1, -1);

      send_frame(3, 2 * W + 3, -1, -1);
      send_frame(0, -1, -1, 10);

      set_win(1, 1, 4, 2);
      send_frame(4, 12, 5, -1);
      aresetn = 0;
      #1;
      chk("midrst_cfg_busy", cfg_busy, 0);
      chk("midrst_cfg_err", cfg_err, 0);
      chk("midrst_win_keep", win_keep, 0);
      chk("midrst_win_sof", win_sof, 0);
      chk("midrst_win_eol", win_eol, 0);
      chk("midrst_line_err", line_err, 0);
      chk("midrst_sof_err", sof_err, 0);
      model_reset();
      @(posedge clk);
      #1;
      aresetn = 1;
      idle(); idle();
      send_frame(0, -1, -1, -1);

      for (int it = 0; it < 40; it++) begin
         cpos = -1;
         if ($urandom_range(0, 2) == 0) begin
            ho = $urandom_range(0, W - 1);
            vo = $urandom_range(0, H - 1);
            w  = $urandom_range(1, W - ho);
            h  = $urandom_range(1, H - vo);
            if ($urandom_range(0, 3) == 0) w = W - ho + 1;
            if ($urandom_range(0, 7) == 0) h = 0;
            set_win(ho, vo, w, h);
            if ($urandom_range(0, 1) == 0) commit();
            else cpos = $urandom_range(1, W * H - 2);
         end
         repeat ($urandom_range(0, 2)) junk(1'($urandom_range(0, 1)));
         fault = $urandom_range(0, 5);
         fpos = -1;
         case (fault)
            1: fpos = $urandom_range(0, H - 1) * W + $urandom_range(0, W - 2);
            2: fpos = $urandom_range(0, H - 1) * W + W - 1;
            3: fpos = $urandom_range(1, W * H - 1);
            default: fault = 0;
         endcase
         stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W * H - 1) : -1;
         send_frame(fault, fpos, cpos, stall);
         idle();
      end

      idle(); idle(); idle();
      chk("qual_queue_left", qq.size(), 0);
      chk("err_queue_left", eq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_crop_ctrl.md
# axis_crop_ctrl

Frame-synchronous window controller for the AXIS video crop datapath. Snoops the input stream handshake and tracks pixel/line position against the nominal input geometry. Holds a runtime-programmable crop window in shadow registers that change only between frames, and drives per-beat keep/SOF/EOL qualifiers to the crop datapath. Detects malformed lines and frames and resynchronises on the next start-of-frame.

## Interface
- VIDEO_IN_W, 1920, input line length in beats
- VIDEO_IN_H, 1080, input lines per frame
- H_OFFSET, 640, reset value of the active and pending horizontal offset
- V_OFFSET, 300, reset value of the active and pending vertical offset
- VIDEO_OUT_W, 640, reset value of the active and pending window width
- VIDEO_OUT_H, 480, reset value of the active and pending window height
- axis_clk  in  1  single clock for all logic
- aresetn  in  1  asynchronous, active-low reset
- cfg_wr_en  in  1  write strobe into pending registers
- cfg_addr  in  2  0=h_off, 1=v_off, 2=width, 3=height
- cfg_wdata  in  16  write data
- cfg_commit  in  1  one-cycle pulse requesting the pending window be applied
- cfg_busy  out  1  commit accepted and not yet applied
- cfg_err  out  1  sticky: last commit rejected as invalid
- mon_tvalid, mon_tready, mon_tuser, mon_tlast  in  1 each  snooped input-side AXIS handshake
- win_keep  out  1  current beat lies inside the active window
- win_sof  out  1  current beat is the window's first pixel
- win_eol  out  1  current beat is the last pixel of a window line
- line_err  out  1  one-cycle pulse on a line-length violation
- sof_err  out  1  one-cycle pulse on an unexpected mid-frame tuser

## Operation
- Beat = mon_tvalid && mon_tready. Counters h_cnt and v_cnt are 16 bit and give the position of the next beat.
- Current coordinate: x = mon_tuser ? 0 : h_cnt; y = mon_tuser ? 0 : v_cnt.
- States:
  - WAIT_SOF: beats without tuser are ignored and all outputs are 0. A beat with tuser moves the block to ACTIVE and sets h_cnt=1, v_cnt=0.
  - ACTIVE: each beat increments h_cnt.
  - If x==VIDEO_IN_W-1 and tlast=1: h_cnt=0 and v_cnt increments. If y==VIDEO_IN_H-1 on that beat, frame end: go to WAIT_SOF with counters 0.
  - If tlast=1 with x!=VIDEO_IN_W-1, or x==VIDEO_IN_W-1 with tlast=0: pulse line_err, go to WAIT_SOF, counters 0.
  - A tuser beat in ACTIVE with (h_cnt,v_cnt)!=(0,0): pulse sof_err and restart the frame exactly as a SOF.
- win_keep = mon_tvalid && (ACTIVE || mon_tuser) && hoff<=x<hoff+w && voff<=y<voff+h. Sums are computed at 17 bits.
- win_sof = win_keep && x==hoff && y==voff.
- win_eol = win_keep && x==hoff+w-1.
- All three qualifiers are combinational from inputs and registers.
- Config writes land in the pending registers on the next edge. A write while busy overwrites pending.
- Commit validation uses the pending values as of the commit cycle. A write in the same cycle is not included. A window is valid when:
  - w!=0 and h!=0
  - hoff+w<=VIDEO_IN_W
  - voff+h<=VIDEO_IN_H
- Invalid commit: cfg_err=1, busy unchanged, active window untouched.
- Valid commit: cfg_err=0, cfg_busy=1.
- Apply (active<=pending, busy->0) happens on the first edge where busy (or a valid commit this cycle) coincides with either:
  - state WAIT_SOF with no beat, or
  - the frame-end beat.
- A commit during ACTIVE therefore takes effect at the next frame boundary. The window never changes mid-frame.

## Timing
- Reset: state WAIT_SOF, h_cnt=v_cnt=0, active and pending = parameter defaults. cfg_busy, cfg_err, line_err and sof_err = 0. win_* = 0.
- Qualifier latency is 0 cycles: valid in the same cycle as the beat.
- Config write to pending: 1 cycle. Commit to cfg_busy: 1 cycle.
- Commit while idle in WAIT_SOF: busy pulses 1 cycle and the window is active from the next cycle.
- Commit on the frame-end beat applies on that edge.
- Error pulses last exactly 1 cycle, in the cycle after the offending beat.
- Reset mid-frame: immediate return to reset values. No error pulses on reset release.
- mon_tvalid low or mon_tready low: counters hold and errors are not evaluated.

## Test plan
- VIDEO_IN_W=8, IN_H=4, default window hoff=2, voff=1, w=3, h=2; one clean frame -> win_keep high on beats x=2..4 for y=1,2 (6 beats). win_sof only at (2,1). win_eol at x=4 on y=1 and y=2.
- Commit hoff=5, w=4 -> cfg_err=1, busy stays 0, the next frame still uses the default window.
- Commit hoff=0, voff=0, w=8, h=4 at the middle of frame 1 -> busy holds until the frame-end beat. Frame 1 keeps the old window. Frame 2 has all 32 beats kept and win_sof on the first beat.
- tlast at x=5 on line 1 -> line_err pulses once and beats are ignored until tuser. The next frame is cropped correctly.
- tuser at (3,2) -> sof_err pulses and that beat is treated as (0,0). Deassert mon_tready for 3 cycles mid-line -> counters hold and keep positions are unchanged. Assert aresetn low mid-frame -> all outputs reset.
